// File: rtl/sap_pkg.sv
// Shared definitions for the RAM dump path: default geometry, frame size and
// the dump FSM state encoding.
package sap_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 8;
    localparam int FRAME_BITS     = DEFAULT_DATA_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SHIFT,
        NEXT,
        DONE
    } dump_state_t;

    // One start bit, the payload, one stop bit.
    function automatic int frame_bits(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Serial bit timer: down-counts CLKS_PER_BIT clocks per bit, pulses bit_tick on
// terminal count and tracks which bit of the frame is on the line.
module tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FRAME_BITS   = 10,
    parameter int IDX_W        = $clog2(FRAME_BITS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic             bit_tick_o,
    output logic [IDX_W-1:0] bit_idx_o
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign bit_tick_o = en_i && (cnt_q == '0);
    assign bit_idx_o  = idx_q;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear_i) begin
            cnt_d = CNT_LOAD;
            idx_d = '0;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_d = CNT_LOAD;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/ram_dump_tx.sv
// Reads a contiguous (possibly wrapping) RAM window through a registered read
// port and streams each word out as a start/data(LSB first)/stop serial frame.
//
//   state | meaning
//   IDLE  | waiting for start; window latched on start
//   READ  | rd_en high for one cycle at cur
//   WAIT  | RAM data arrives, loaded into the shift register
//   SHIFT | frame on tx, CLKS_PER_BIT clocks per bit
//   NEXT  | advance cur or finish
//   DONE  | one-cycle done pulse
module ram_dump_tx
    import sap_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int               FBITS    = frame_bits(DATA_W);
    localparam int               IDX_W    = $clog2(FBITS);
    localparam logic [IDX_W-1:0] IDX_STOP = IDX_W'(FBITS - 1);
    localparam logic [IDX_W-1:0] IDX_DATA = IDX_W'(DATA_W);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmr_clear, tmr_en, bit_tick;
    logic [IDX_W-1:0]  bit_idx;

    tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FRAME_BITS   (FBITS),
        .IDX_W        (IDX_W)
    ) u_bit_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (tmr_clear),
        .en_i       (tmr_en),
        .bit_tick_o (bit_tick),
        .bit_idx_o  (bit_idx)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        shreg_d   = shreg_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = 1'b0;
        tx_d      = 1'b1;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        // Registered outputs are set up on the edge that enters each state.
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    cur_d     = first_addr_i;
                    last_d    = last_addr_i;
                    rd_addr_d = first_addr_i;
                    rd_en_d   = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                shreg_d   = rd_data_i;
                tx_d      = 1'b0;
                tmr_clear = 1'b1;
                state_d   = SHIFT;
            end
            SHIFT: begin
                tmr_en = 1'b1;
                tx_d   = tx_q;
                if (bit_tick) begin
                    if (bit_idx == IDX_STOP) begin
                        tx_d    = 1'b1;
                        state_d = NEXT;
                    end else if (bit_idx < IDX_DATA) begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
            end
            NEXT: begin
                if (cur_q == last_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cur_d     = cur_q + ADDR_W'(1);
                    rd_addr_d = cur_q + ADDR_W'(1);
                    rd_en_d   = 1'b1;
                    state_d   = READ;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            last_q    <= '0;
            shreg_q   <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            shreg_q   <= shreg_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_ram_dump_tx.sv
// Bench for ram_dump_tx: table of dump windows plus random windows, each checked
// cycle by cycle against a frame-timing model and a free-running serial decoder.
module tb_ram_dump_tx;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int WCYC  = 10 * CPB + 3;
    localparam int MAXC  = 16 * WCYC + 8;

    typedef struct {
        logic [3:0] first;
        logic [3:0] last;
        bit         incr;
        int         poke_at;
        logic [3:0] pf;
        logic [3:0] pl;
        int         frames;
        int         done_cyc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] first_addr = '0;
    logic [3:0] last_addr = '0;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic       tx, busy, done;

    logic [7:0] mem [16];

    int n_vec = 0;
    int n_err = 0;

    bit         cap_tx   [MAXC];
    bit         cap_rden [MAXC];
    bit         cap_busy [MAXC];
    bit         cap_done [MAXC];
    logic [3:0] cap_addr [MAXC];
    int         cap_len;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    ram_dump_tx #(.ADDR_W(4), .DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .first_addr_i (first_addr),
        .last_addr_i  (last_addr),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .tx_o         (tx),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample j is taken on the falling edge after the j-th rising edge, where
    // rising edge 0 is the one that samples start.
    task automatic capture(input logic [3:0] f, input logic [3:0] l, input int len,
                           input int poke_at, input logic [3:0] pf, input logic [3:0] pl);
        @(negedge clk);
        start = 1'b1; first_addr = f; last_addr = l;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            cap_tx[j]   = tx;
            cap_rden[j] = rd_en;
            cap_busy[j] = busy;
            cap_done[j] = done;
            cap_addr[j] = rd_addr;
            start = 1'b0;
            first_addr = 4'($urandom);
            last_addr  = 4'($urandom);
            if (j == poke_at) begin
                start = 1'b1; first_addr = pf; last_addr = pl;
            end
        end
        @(negedge clk);
        start = 1'b0;
        cap_len = len;
    endtask

    // Expected waveform from the frame rules: word w occupies cycles
    // [w*WCYC, (w+1)*WCYC); its frame bit b is on tx for cycles 2+b*CPB .. 2+b*CPB+CPB-1.
    task automatic check_trace(input string tag, input logic [3:0] f, input int n);
        int bad_j [5];
        int bad_a [5];
        int bad_e [5];
        int act [5];
        int exp [5];
        string nm [5];
        nm[0] = "tx"; nm[1] = "rd_en"; nm[2] = "rd_addr"; nm[3] = "busy"; nm[4] = "done";
        for (int k = 0; k < 5; k++) bad_j[k] = -1;
        for (int j = 0; j < cap_len; j++) begin
            int w, ph, wc, b;
            logic [7:0] d;
            w  = j / WCYC;
            ph = j % WCYC;
            wc = (w < n) ? w : n - 1;
            d  = mem[(int'(f) + wc) % 16];
            exp[0] = 1;
            if (j < n * WCYC && ph >= 2 && ph < 2 + 10 * CPB) begin
                b = (ph - 2) / CPB;
                if (b == 0) exp[0] = 0;
                else if (b <= DW) exp[0] = int'(d[b-1]);
            end
            exp[1] = (j < n * WCYC && ph == 0) ? 1 : 0;
            exp[2] = (int'(f) + wc) % 16;
            exp[3] = (j < n * WCYC) ? 1 : 0;
            exp[4] = (j == n * WCYC) ? 1 : 0;
            act[0] = int'(cap_tx[j]);
            act[1] = int'(cap_rden[j]);
            act[2] = int'(cap_addr[j]);
            act[3] = int'(cap_busy[j]);
            act[4] = int'(cap_done[j]);
            for (int k = 0; k < 5; k++)
                if (act[k] != exp[k] && bad_j[k] < 0) begin
                    bad_j[k] = j; bad_a[k] = act[k]; bad_e[k] = exp[k];
                end
        end
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (bad_j[k] >= 0) begin
                n_err++;
                $display("FAIL %s %s trace at cycle %0d: got %0h expected %0h",
                         tag, nm[k], bad_j[k], bad_a[k], bad_e[k]);
            end
        end
    endtask

    // Independent serial receiver over the captured tx line.
    task automatic decode_check(input string tag, input logic [3:0] f, input int n,
                                input int exp_done);
        logic [7:0] dec [16];
        int got = 0;
        int j = 0;
        int pulses = 0;
        int first_done = -1;
        while (j < cap_len) begin
            if (cap_tx[j] == 1'b0) begin
                logic [7:0] v;
                for (int i = 0; i < 8; i++) begin
                    int idx = j + CPB * (i + 1) + CPB / 2;
                    v[i] = (idx < cap_len) ? cap_tx[idx] : 1'b1;
                end
                if (got < 16) dec[got] = v;
                got++;
                j += 10 * CPB;
            end else begin
                j++;
            end
        end
        for (int k = 0; k < cap_len; k++) begin
            if (cap_rden[k]) pulses++;
            if (cap_done[k] && first_done < 0) first_done = k;
        end
        chk({tag, " frame count"}, got, n);
        chk({tag, " rd_en pulses"}, pulses, n);
        chk({tag, " done cycle"}, first_done, exp_done);
        for (int w = 0; w < n && w < got && w < 16; w++)
            chk($sformatf("%s payload %0d", tag, w), int'(dec[w]),
                int'(mem[(int'(f) + w) % 16]));
    endtask

    task automatic preset_mem(input bit incr);
        for (int i = 0; i < 16; i++) mem[i] = incr ? 8'(i) : 8'(8'h30 + 8'(i * 7));
        if (!incr) begin
            mem[9] = 8'h01; mem[10] = 8'h08; mem[3] = 8'hA5;
        end
    endtask

    function automatic int words(input logic [3:0] f, input logic [3:0] l);
        return ((int'(l) - int'(f)) & 15) + 1;
    endfunction

    vec_t tbl [7];

    initial begin
        int n, dcount;
        logic [3:0] f, l;

        tbl[0] = '{4'h0, 4'hF, 1'b1, -1, 4'h0, 4'h0, 16, 688};
        tbl[1] = '{4'h9, 4'hA, 1'b0, -1, 4'h0, 4'h0,  2,  86};
        tbl[2] = '{4'h3, 4'h3, 1'b0, -1, 4'h0, 4'h0,  1,  43};
        tbl[3] = '{4'hE, 4'h1, 1'b0, -1, 4'h0, 4'h0,  4, 172};
        tbl[4] = '{4'hE, 4'h1, 1'b0, 60, 4'h5, 4'h7,  4, 172};
        tbl[5] = '{4'h3, 4'h3, 1'b0, 43, 4'h0, 4'hF,  1,  43};
        tbl[6] = '{4'h7, 4'h7, 1'b0, 42, 4'h0, 4'hF,  1,  43};

        preset_mem(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tx", int'(tx), 1);
        chk("reset rd_en", int'(rd_en), 0);
        chk("reset rd_addr", int'(rd_addr), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        reset = 1'b0;

        for (int t = 0; t < 7; t++) begin
            preset_mem(tbl[t].incr);
            n = words(tbl[t].first, tbl[t].last);
            capture(tbl[t].first, tbl[t].last, n * WCYC + 3, tbl[t].poke_at, tbl[t].pf, tbl[t].pl);
            check_trace($sformatf("tbl%0d", t), tbl[t].first, n);
            decode_check($sformatf("tbl%0d", t), tbl[t].first, tbl[t].frames, tbl[t].done_cyc);
        end

        // Reset during a data bit of A5 that is 0 on the line.
        preset_mem(1'b0);
        @(negedge clk);
        start = 1'b1; first_addr = 4'h3; last_addr = 4'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        chk("pre-reset tx", int'(tx), 0);
        chk("pre-reset busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset tx", int'(tx), 1);
        chk("async reset busy", int'(busy), 0);
        chk("async reset rd_en", int'(rd_en), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) dcount++;
            if (!tx) dcount += 100;
        end
        chk("no done/tx activity after abort", dcount, 0);
        capture(4'h9, 4'h9, WCYC + 3, -1, 4'h0, 4'h0);
        check_trace("after-reset", 4'h9, 1);
        decode_check("after-reset", 4'h9, 1, 43);

        for (int r = 0; r < 6; r++) begin
            int pk;
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            f = 4'($urandom);
            l = 4'($urandom);
            n = words(f, l);
            pk = $urandom_range(n * WCYC - 1, 1);
            capture(f, l, n * WCYC + 3, pk, 4'($urandom), 4'($urandom));
            check_trace($sformatf("rnd%0d", r), f, n);
            decode_check($sformatf("rnd%0d", r), f, n, n * WCYC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
